nd_2to1_arb: RTL and testbench
==============================

// Module: nd_2to1_arb
// PURPOSE
//  Merge node: two inbound message channels (rcv0, rcv1) share one outbound channel (snd0).
//  Each input has its own FIFO; an arbiter picks which FIFO feeds snd0.
//  Round-robin by default, fixed rcv0 priority optional.
//  Sits upstream of 1-to-2 split nodes to build fan-in trees in the hlang network.
// PARAMETERS
//  FSZ       `NS_MESSAGE_FIFO_SIZE  per-input FIFO depth; power of 2, >=2
//  ASZ       `NS_ADDRESS_SIZE       width of src/dst fields
//  DSZ       `NS_DATA_SIZE          width of dat field
//  RSZ       `NS_REDUN_SIZE         width of red field
//  PRIO_MODE 0                      0 = round-robin; 1 = fixed priority, rcv0 wins
// PORTS
//  i_clk           in   1    single clock, all state on posedge
//  reset           in   1    asynchronous, active-low; 0 clears all state immediately
//  ready           out  1    1 = node initialised and operating
//  snd0_src/_dst   out  ASZ  outbound message address fields
//  snd0_dat        out  DSZ  outbound data
//  snd0_red        out  RSZ  outbound redundancy
//  snd0_req        out  1    outbound request
//  snd0_ack        in   1    outbound acknowledge
//  rcvN_src/_dst   in   ASZ  inbound address fields, N = 0,1
//  rcvN_dat/_red   in   DSZ/RSZ  inbound data / redundancy
//  rcvN_req        in   1    inbound request
//  rcvN_ack        out  1    inbound acknowledge
// BEHAVIOUR
//  Reset (reset=0, async): ready, snd0_req, rcv0_ack, rcv1_ack = 0.
//   snd0 fields = 0; FIFOs empty; out FSM = IDLE; rr pointer -> rcv0.
//   Reset mid-transfer drops all queued and in-flight messages.
//  Init: first posedge with reset=1 sets ready=1. No channel activity while ready=0.
//  Handshake, all channels, 4-phase: req up (fields stable) -> ack up -> req down -> ack down.
//  Input N, per cycle:
//   - Push when rcvN_req=1, rcvN_ack=0 and FIFO N not full.
//   - Push writes the fields to FIFO N and sets rcvN_ack=1 at that edge.
//   - FIFO N full: ack stays 0 (backpressure) until a slot frees.
//   - rcvN_ack clears on the edge after rcvN_req is sampled 0.
//  FIFO:
//   - Count 0..FSZ; head/tail pointers wrap modulo FSZ.
//   - Push and pop on the same FIFO in one cycle: count unchanged; legal even when full.
//  Output FSM:
//   - IDLE: if any FIFO non-empty, grant one, pop it into the snd0 regs, snd0_req<=1 -> SEND.
//   - SEND: hold fields; on snd0_ack=1, snd0_req<=0 -> BUSY.
//   - BUSY: on snd0_ack=0 -> IDLE.
//  Arbitration (IDLE only):
//   - Only one FIFO non-empty: grant it.
//   - Both non-empty, PRIO_MODE=0: grant the FIFO not granted last; rr pointer updates on each grant.
//   - Both non-empty, PRIO_MODE=1: always grant rcv0.
//  Latency: rcvN_req sampled at edge E (FIFO empty, FSM IDLE) -> snd0_req=1 after edge E+1.
//  Throughput: at most one message per 3 cycles with a zero-delay downstream ack.
//  Order preserved within each input; no ordering guarantee across inputs.
//  snd0 fields change only on the IDLE->SEND edge.
// TESTING
//  T1 single: rcv0 msg dst=5 dat=0xA; downstream acks in 1 cycle
//     -> snd0_req up 2 cycles after rcv0_req; dst=5 dat=0xA; rcv0_ack pulses once.
//  T2 rr: 4 msgs preloaded per input (rcv0 dat 0..3, rcv1 dat 10..13), PRIO_MODE=0
//     -> snd0 order 0,10,1,11,2,12,3,13.
//  T3 prio: same stimulus, PRIO_MODE=1 -> snd0 order 0,1,2,3,10,11,12,13.
//  T4 full: FSZ=4, snd0_ack held 0, 6 msgs on rcv1
//     -> 5 accepted (1 in snd0 regs, 4 queued); 6th rcv1_ack stays 0.
//     -> Acking snd0 frees a slot; 6th accepted within 2 cycles.
//  T5 async reset: assert reset=0 mid-SEND with both FIFOs non-empty
//     -> snd0_req, acks, ready drop immediately; after release ready=1 at first edge, FIFOs empty.
//  T6 simultaneous: FIFO0 full with push and pop in the same cycle -> count stays FSZ; no loss or duplication.

Source files
------------

// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: two-input merge node. Each inbound channel (rcv0, rcv1) feeds
// its own message FIFO; an output FSM drains the FIFOs onto snd0 using either
// round-robin or fixed rcv0-first arbitration. All channels use a 4-phase
// req/ack handshake with fields held stable while req is high.
module nd_2to1_arb #(
    parameter int FSZ       = 4,
    parameter int ASZ       = 8,
    parameter int DSZ       = 16,
    parameter int RSZ       = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack
);

    // Packed message layout: {src, dst, dat, red}
    localparam int MW = 2 * ASZ + DSZ + RSZ;
    // FSZ is a power of two, so PW-bit pointers wrap modulo FSZ by themselves
    localparam int PW = $clog2(FSZ);
    localparam int CW = $clog2(FSZ + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [MW-1:0]  mem_r [2][FSZ];
    logic [PW-1:0]  head_r [2];
    logic [PW-1:0]  tail_r [2];
    logic [CW-1:0]  cnt_r [2];
    logic [MW-1:0]  msg_in_s [2];
    logic [MW-1:0]  head_msg_s;

    logic [1:0]     req_s;
    logic [1:0]     empty_s;
    logic [1:0]     full_s;
    logic [1:0]     push_s;
    logic [1:0]     pop_s;
    logic [1:0]     ack_r;
    logic           grant_s;
    logic           rr_ptr_r;
    logic           ready_r;
    logic [1:0]     state_r;

    logic [ASZ-1:0] src_r;
    logic [ASZ-1:0] dst_r;
    logic [DSZ-1:0] dat_r;
    logic [RSZ-1:0] red_r;
    logic           snd_req_r;

    assign ready    = ready_r;
    assign snd0_src = src_r;
    assign snd0_dst = dst_r;
    assign snd0_dat = dat_r;
    assign snd0_red = red_r;
    assign snd0_req = snd_req_r;
    assign rcv0_ack = ack_r[0];
    assign rcv1_ack = ack_r[1];

    // Pack inbound fields and derive per-FIFO empty/full flags
    always_comb begin
        msg_in_s[0] = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
        msg_in_s[1] = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};
        req_s       = {rcv1_req, rcv0_req};
        empty_s     = 2'b00;
        full_s      = 2'b00;
        for (int n = 0; n < 2; n++) begin
            empty_s[n] = (cnt_r[n] == CW'(0));
            full_s[n]  = (cnt_r[n] == CW'(FSZ));
        end
    end

    // Arbiter: choose which FIFO to pop while the output FSM is idle
    always_comb begin
        grant_s = 1'b0;
        pop_s   = 2'b00;
        if (ready_r && (state_r == ST_IDLE)) begin
            if (!empty_s[0] && !empty_s[1]) begin
                if (PRIO_MODE != 0) begin
                    grant_s = 1'b0;
                end else begin
                    grant_s = rr_ptr_r;
                end
                pop_s = grant_s ? 2'b10 : 2'b01;
            end else if (!empty_s[0]) begin
                grant_s = 1'b0;
                pop_s   = 2'b01;
            end else if (!empty_s[1]) begin
                grant_s = 1'b1;
                pop_s   = 2'b10;
            end else begin
                grant_s = 1'b0;
                pop_s   = 2'b00;
            end
        end else begin
            grant_s = 1'b0;
            pop_s   = 2'b00;
        end
        head_msg_s = mem_r[grant_s][head_r[grant_s]];
    end

    // Push qualification: a full FIFO still accepts when it is popped this cycle
    always_comb begin
        push_s = 2'b00;
        for (int n = 0; n < 2; n++) begin
            push_s[n] = ready_r && req_s[n] && !ack_r[n] && (!full_s[n] || pop_s[n]);
        end
    end

    // FIFO pointers, occupancy and inbound acknowledge
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                head_r[n] <= PW'(0);
                tail_r[n] <= PW'(0);
                cnt_r[n]  <= CW'(0);
            end
            ack_r <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_s[n]) begin
                    tail_r[n] <= tail_r[n] + PW'(1);
                end
                if (pop_s[n]) begin
                    head_r[n] <= head_r[n] + PW'(1);
                end
                case ({push_s[n], pop_s[n]})
                    2'b10:   cnt_r[n] <= cnt_r[n] + CW'(1);
                    2'b01:   cnt_r[n] <= cnt_r[n] - CW'(1);
                    default: cnt_r[n] <= cnt_r[n];
                endcase
                if (push_s[n]) begin
                    ack_r[n] <= 1'b1;
                end else if (ack_r[n] && !req_s[n]) begin
                    ack_r[n] <= 1'b0;
                end else begin
                    ack_r[n] <= ack_r[n];
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy is cleared
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push_s[n]) begin
                mem_r[n][tail_r[n]] <= msg_in_s[n];
            end
        end
    end

    // Output FSM: load snd0 regs on grant, then run the outbound 4-phase handshake
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready_r   <= 1'b0;
            state_r   <= ST_IDLE;
            rr_ptr_r  <= 1'b0;
            snd_req_r <= 1'b0;
            src_r     <= ASZ'(0);
            dst_r     <= ASZ'(0);
            dat_r     <= DSZ'(0);
            red_r     <= RSZ'(0);
        end else begin
            ready_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s != 2'b00) begin
                        {src_r, dst_r, dat_r, red_r} <= head_msg_s;
                        snd_req_r <= 1'b1;
                        rr_ptr_r  <= ~grant_s;
                        state_r   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (snd0_ack) begin
                        snd_req_r <= 1'b0;
                        state_r   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!snd0_ack) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    snd_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nd_2to1_arb.sv
// Directed bench for nd_2to1_arb. Instance 0 runs round-robin, instance 1 runs
// fixed rcv0 priority; both use FSZ=4. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_nd_2to1_arb;

    localparam int ASZ = 8;
    localparam int DSZ = 16;
    localparam int RSZ = 4;
    localparam int FSZ = 4;

    logic           clk = 1'b0;
    logic           reset;

    logic [ASZ-1:0] in_src [2][2];
    logic [ASZ-1:0] in_dst [2][2];
    logic [DSZ-1:0] in_dat [2][2];
    logic [RSZ-1:0] in_red [2][2];
    logic           in_req [2][2];
    logic           in_ack [2][2];

    logic [ASZ-1:0] out_src [2];
    logic [ASZ-1:0] out_dst [2];
    logic [DSZ-1:0] out_dat [2];
    logic [RSZ-1:0] out_red [2];
    logic           out_req [2];
    logic           out_ack [2];
    logic           rdy [2];

    int checks = 0;
    int errors = 0;

    int rr_ord [8] = '{0, 10, 1, 11, 2, 12, 3, 13};
    int pr_ord [8] = '{0, 1, 2, 3, 10, 11, 12, 13};

    always #5 clk = ~clk;

    nd_2to1_arb #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .PRIO_MODE(0)) dut_rr (
        .i_clk(clk), .reset(reset), .ready(rdy[0]),
        .snd0_src(out_src[0]), .snd0_dst(out_dst[0]), .snd0_dat(out_dat[0]),
        .snd0_red(out_red[0]), .snd0_req(out_req[0]), .snd0_ack(out_ack[0]),
        .rcv0_src(in_src[0][0]), .rcv0_dst(in_dst[0][0]), .rcv0_dat(in_dat[0][0]),
        .rcv0_red(in_red[0][0]), .rcv0_req(in_req[0][0]), .rcv0_ack(in_ack[0][0]),
        .rcv1_src(in_src[0][1]), .rcv1_dst(in_dst[0][1]), .rcv1_dat(in_dat[0][1]),
        .rcv1_red(in_red[0][1]), .rcv1_req(in_req[0][1]), .rcv1_ack(in_ack[0][1])
    );

    nd_2to1_arb #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .PRIO_MODE(1)) dut_pr (
        .i_clk(clk), .reset(reset), .ready(rdy[1]),
        .snd0_src(out_src[1]), .snd0_dst(out_dst[1]), .snd0_dat(out_dat[1]),
        .snd0_red(out_red[1]), .snd0_req(out_req[1]), .snd0_ack(out_ack[1]),
        .rcv0_src(in_src[1][0]), .rcv0_dst(in_dst[1][0]), .rcv0_dat(in_dat[1][0]),
        .rcv0_red(in_red[1][0]), .rcv0_req(in_req[1][0]), .rcv0_ack(in_ack[1][0]),
        .rcv1_src(in_src[1][1]), .rcv1_dst(in_dst[1][1]), .rcv1_dat(in_dat[1][1]),
        .rcv1_red(in_red[1][1]), .rcv1_req(in_req[1][1]), .rcv1_ack(in_ack[1][1])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [ASZ-1:0] dst_of(input int dat);
        logic [ASZ-1:0] v;
        v = ASZ'(dat);
        return v ^ 8'h5A;
    endfunction

    // Present a message on input n of instance d and raise req
    task automatic raise_req(input int d, input int n, input int dat, input logic [ASZ-1:0] dst);
        logic [DSZ-1:0] dv;
        dv = DSZ'(dat);
        in_src[d][n] = ASZ'(n + 1);
        in_dst[d][n] = dst;
        in_dat[d][n] = dv;
        in_red[d][n] = dv[RSZ-1:0];
        in_req[d][n] = 1'b1;
    endtask

    task automatic wait_ack(input int d, input int n, input logic val, input int maxc, output int cyc);
        cyc = 0;
        while (in_ack[d][n] !== val && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Complete one inbound 4-phase transfer
    task automatic send_msg(input int d, input int n, input int dat);
        int c;
        raise_req(d, n, dat, dst_of(dat));
        @(negedge clk);
        wait_ack(d, n, 1'b1, 20, c);
        check_val("send_ack_up", 32'(in_ack[d][n]), 32'd1);
        in_req[d][n] = 1'b0;
        @(negedge clk);
        wait_ack(d, n, 1'b0, 20, c);
        check_val("send_ack_down", 32'(in_ack[d][n]), 32'd0);
    endtask

    // Wait for snd0 request, check the fields, then complete the outbound handshake
    task automatic recv_msg(input int d, input int dat, input logic [ASZ-1:0] dst, input int src);
        int c;
        logic [DSZ-1:0] dv;
        dv = DSZ'(dat);
        c = 0;
        while (out_req[d] !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check_val("recv_req_up", 32'(out_req[d]), 32'd1);
        check_val("recv_dat", 32'(out_dat[d]), 32'(dv));
        check_val("recv_dst", 32'(out_dst[d]), 32'(dst));
        check_val("recv_src", 32'(out_src[d]), 32'(src));
        check_val("recv_red", 32'(out_red[d]), 32'(dv[RSZ-1:0]));
        out_ack[d] = 1'b1;
        @(negedge clk);
        c = 0;
        while (out_req[d] !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_val("recv_req_down", 32'(out_req[d]), 32'd0);
        out_ack[d] = 1'b0;
    endtask

    // Fill input n to capacity, verify backpressure and simultaneous push/pop at full
    task automatic full_test(input int d, input int n, input int base);
        int c;
        for (int i = 0; i < 5; i++) begin
            send_msg(d, n, base + i);
        end
        raise_req(d, n, base + 5, dst_of(base + 5));
        repeat (4) @(negedge clk);
        check_val("full_sixth_blocked", 32'(in_ack[d][n]), 32'd0);
        recv_msg(d, base, dst_of(base), n + 1);
        wait_ack(d, n, 1'b1, 10, c);
        check_val("full_sixth_accept_cycles", 32'(c), 32'd2);
        in_req[d][n] = 1'b0;
        @(negedge clk);
        wait_ack(d, n, 1'b0, 10, c);
        raise_req(d, n, base + 6, dst_of(base + 6));
        repeat (4) @(negedge clk);
        check_val("full_count_held", 32'(in_ack[d][n]), 32'd0);
        recv_msg(d, base + 1, dst_of(base + 1), n + 1);
        wait_ack(d, n, 1'b1, 10, c);
        check_val("full_seventh_accept_cycles", 32'(c), 32'd2);
        in_req[d][n] = 1'b0;
        @(negedge clk);
        wait_ack(d, n, 1'b0, 10, c);
        for (int i = 2; i < 7; i++) begin
            recv_msg(d, base + i, dst_of(base + i), n + 1);
        end
        repeat (3) @(negedge clk);
        check_val("full_no_extra", 32'(out_req[d]), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            out_ack[d] = 1'b0;
            for (int n = 0; n < 2; n++) begin
                in_src[d][n] = '0;
                in_dst[d][n] = '0;
                in_dat[d][n] = '0;
                in_red[d][n] = '0;
                in_req[d][n] = 1'b0;
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_ready", 32'(rdy[d]), 32'd0);
            check_val("rst_snd_req", 32'(out_req[d]), 32'd0);
            check_val("rst_snd_dat", 32'(out_dat[d]), 32'd0);
            check_val("rst_ack0", 32'(in_ack[d][0]), 32'd0);
            check_val("rst_ack1", 32'(in_ack[d][1]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_val("init_ready", 32'(rdy[0]), 32'd1);

        // T1: single message latency and ack pulse
        raise_req(0, 0, 32'hA, 8'd5);
        @(negedge clk);
        check_val("t1_ack_up", 32'(in_ack[0][0]), 32'd1);
        check_val("t1_req_early", 32'(out_req[0]), 32'd0);
        @(negedge clk);
        check_val("t1_req_up", 32'(out_req[0]), 32'd1);
        check_val("t1_dst", 32'(out_dst[0]), 32'd5);
        check_val("t1_dat", 32'(out_dat[0]), 32'hA);
        in_req[0][0] = 1'b0;
        @(negedge clk);
        check_val("t1_ack_clear", 32'(in_ack[0][0]), 32'd0);
        out_ack[0] = 1'b1;
        @(negedge clk);
        check_val("t1_req_down", 32'(out_req[0]), 32'd0);
        out_ack[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_val("t1_ack_once", 32'(in_ack[0][0]), 32'd0);
        check_val("t1_dat_held", 32'(out_dat[0]), 32'hA);
        check_val("t1_no_resend", 32'(out_req[0]), 32'd0);

        // T2/T3: preload both inputs on both instances, then drain
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) send_msg(d, 0, i);
            for (int i = 0; i < 4; i++) send_msg(d, 1, 10 + i);
        end
        for (int i = 0; i < 8; i++) recv_msg(0, rr_ord[i], dst_of(rr_ord[i]), (rr_ord[i] >= 10) ? 2 : 1);
        for (int i = 0; i < 8; i++) recv_msg(1, pr_ord[i], dst_of(pr_ord[i]), (pr_ord[i] >= 10) ? 2 : 1);

        // T4 on rcv1 of the round-robin instance, T6 on rcv0 of the priority instance
        full_test(0, 1, 20);
        full_test(1, 0, 40);

        // T5: asynchronous reset mid-SEND with both FIFOs occupied
        send_msg(0, 0, 50);
        send_msg(0, 0, 51);
        send_msg(0, 1, 60);
        send_msg(0, 1, 61);
        check_val("t5_in_send", 32'(out_req[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_req_drop", 32'(out_req[0]), 32'd0);
        check_val("t5_ready_drop", 32'(rdy[0]), 32'd0);
        check_val("t5_dat_clear", 32'(out_dat[0]), 32'd0);
        check_val("t5_ack0", 32'(in_ack[0][0]), 32'd0);
        check_val("t5_ack1", 32'(in_ack[0][1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("t5_ready_back", 32'(rdy[0]), 32'd1);
        repeat (4) @(negedge clk);
        check_val("t5_fifos_empty", 32'(out_req[0]), 32'd0);
        send_msg(0, 1, 70);
        recv_msg(0, 70, dst_of(70), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
